// File: rtl/gfx_pkg.sv
// Shared widths, payload types and FSM states for the vertex transform unit.
package gfx_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned MAT_W   = 14;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned ONE_Q4  = 16;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [MAT_W-1:0]   elem_t;
  typedef logic signed [OUT_W-1:0]   clip_t;

  typedef coord_t [3:0]  vec4_t;
  typedef elem_t  [15:0] mat4_t;
  typedef clip_t  [3:0]  clipv_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/vtu_mac_lane.sv
// One matrix row: accumulates element*coordinate products at full precision.
module vtu_mac_lane #(
  parameter int unsigned ELEM_W = gfx_pkg::MAT_W,
  parameter int unsigned CRD_W  = gfx_pkg::COORD_W,
  parameter int unsigned ACC_W  = gfx_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [ELEM_W-1:0] elem_i,
  input  logic signed [CRD_W-1:0]  coord_i,
  output logic signed [ACC_W-1:0]  sum_c_o
);

  localparam int unsigned PROD_W = ELEM_W + CRD_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  assign prod    = PROD_W'(elem_i) * PROD_W'(coord_i);
  assign sum_c_o = acc_q + ACC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum_c_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/vertex_transform_unit.sv
// Streaming 4x4 fixed-point vertex transform with a double-buffered matrix.
module vertex_transform_unit #(
  parameter int unsigned COORD_W = gfx_pkg::COORD_W,
  parameter int unsigned MAT_W   = gfx_pkg::MAT_W,
  parameter int unsigned OUT_W   = gfx_pkg::OUT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mat_we,
  input  logic [3:0]                mat_addr,
  input  logic signed [MAT_W-1:0]   mat_wdata,
  input  logic                      mat_commit,
  output logic                      commit_pend,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [COORD_W-1:0] s_x,
  input  logic signed [COORD_W-1:0] s_y,
  input  logic signed [COORD_W-1:0] s_z,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [OUT_W-1:0]   m_x,
  output logic signed [OUT_W-1:0]   m_y,
  output logic signed [OUT_W-1:0]   m_z,
  output logic signed [OUT_W-1:0]   m_w,
  output logic                      m_last,
  output logic [15:0]               vtx_count
);

  import gfx_pkg::*;

  state_e                   state_q, state_d;
  logic [1:0]               col_q, col_d;
  logic [3:0][COORD_W-1:0]  v_q, v_d;
  logic                     last_q, last_d;
  logic [15:0][MAT_W-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic                     pend_q, pend_d;
  logic                     m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [3:0][OUT_W-1:0]    m_q, m_d;
  logic [15:0]              vtx_q, vtx_d;
  logic                     lane_clr, lane_en, accept, apply;
  logic [3:0][OUT_W-1:0]    lane_sum;

  assign s_ready     = (state_q == IDLE);
  assign accept      = s_ready && s_valid;
  assign apply       = pend_q && (state_q == IDLE) && !accept;
  assign commit_pend = pend_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_x         = m_q[0];
  assign m_y         = m_q[1];
  assign m_z         = m_q[2];
  assign m_w         = m_q[3];
  assign vtx_count   = vtx_q;

  // Row r of the active matrix against coordinate col, all rows in parallel.
  for (genvar r = 0; r < 4; r++) begin : g_lane
    vtu_mac_lane #(.ELEM_W(MAT_W), .CRD_W(COORD_W), .ACC_W(OUT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (lane_clr),
      .en_i    (lane_en),
      .elem_i  (active_q[{2'(r), col_q}]),
      .coord_i (v_q[col_q]),
      .sum_c_o (lane_sum[r])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    v_d       = v_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_d       = m_q;
    vtx_d     = vtx_q;
    lane_clr  = 1'b0;
    lane_en   = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pend_d    = pend_q;

    unique case (state_q)
      IDLE: if (accept) begin
        v_d      = {COORD_W'(ONE_Q4), s_z, s_y, s_x};
        last_d   = s_last;
        col_d    = 2'd0;
        lane_clr = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        lane_en = 1'b1;
        col_d   = col_q + 2'd1;
        if (col_q == 2'd3) begin
          m_d       = lane_sum;
          m_last_d  = last_q;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        vtx_d     = vtx_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A commit arriving with a write stays pending so the copy sees that write.
    if (mat_we) shadow_d[mat_addr] = mat_wdata;
    if (apply)  active_d = shadow_q;
    if (mat_commit) pend_d = 1'b1;
    else if (apply) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      v_q       <= '0;
      last_q    <= 1'b0;
      pend_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_q       <= '0;
      vtx_q     <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? MAT_W'(1) : '0;
        active_q[i] <= (i % 5 == 0) ? MAT_W'(1) : '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      v_q       <= v_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_q       <= m_d;
      vtx_q     <= vtx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

endmodule
